// File: rtl/fc_score_tx_if.sv
// fc_score_tx_if: feature-in / class-score-out stream bundle.
// master = upstream/test side, slave = fc_score_tx.
interface fc_score_tx_if;
    logic        valid_in;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        valid_out;
    logic        busy;

    modport master (
        output valid_in,
        output data_in,
        input  data_out,
        input  valid_out,
        input  busy
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output data_out,
        output valid_out,
        output busy
    );
endinterface

// File: rtl/fc_score_tx.sv
// fc_score_tx: final FC layer, ten parallel class dot products
// streamed out as saturated 12-bit scores followed by an idle gap.
module fc_score_tx #(
    parameter int N_IN    = 48,
    parameter int N_CLS   = 10,
    parameter int W_W     = 8,
    parameter int ACC_W   = 32,
    parameter int FRAC    = 7,
    parameter int GAP_CYC = 8,
    parameter logic [N_CLS*N_IN*W_W-1:0] W_INIT = '0,
    parameter logic [N_CLS*W_W-1:0]      B_INIT = '0
) (
    input logic          clk,
    input logic          rst_n,
    fc_score_tx_if.slave bus
);
    localparam int P_W     = 12 + W_W;
    localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_MAX = (N_CLS > GAP_CYC) ? N_CLS : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_FINAL = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic [11:0]      data_q;

    logic signed [W_W-1:0]   w_rom [N_CLS][N_IN];
    logic signed [W_W-1:0]   b_rom [N_CLS];
    logic signed [ACC_W-1:0] acc   [N_CLS];
    logic signed [11:0]      score [N_CLS];

    logic signed [P_W-1:0]   prod_raw [N_CLS];
    logic signed [ACC_W-1:0] prod     [N_CLS];
    logic signed [ACC_W-1:0] b_ext    [N_CLS];
    logic signed [ACC_W-1:0] bsum     [N_CLS];
    logic signed [ACC_W-1:0] shr      [N_CLS];
    logic signed [11:0]      sat      [N_CLS];

    for (genvar k = 0; k < N_CLS; k++) begin : g_rom
        assign b_rom[k] = B_INIT[k*W_W +: W_W];
        for (genvar i = 0; i < N_IN; i++) begin : g_w
            assign w_rom[k][i] = W_INIT[(k*N_IN+i)*W_W +: W_W];
        end
    end

    // Bias is pre-scaled so the single shift floors the biased sum.
    always_comb begin
        for (int k = 0; k < N_CLS; k++) begin
            prod_raw[k] = P_W'($signed(bus.data_in)) * P_W'(w_rom[k][idx]);
            prod[k]  = {{(ACC_W-P_W){prod_raw[k][P_W-1]}}, prod_raw[k]};
            b_ext[k] = {{(ACC_W-W_W){b_rom[k][W_W-1]}}, b_rom[k]};
            bsum[k]  = acc[k] + (b_ext[k] <<< FRAC);
            shr[k]   = bsum[k] >>> FRAC;
            if (shr[k] > 2047) begin
                sat[k] = 12'sh7ff;
            end else if (shr[k] < -2048) begin
                sat[k] = 12'sh800;
            end else begin
                sat[k] = shr[k][11:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            for (int k = 0; k < N_CLS; k++) begin
                acc[k]   <= '0;
                score[k] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        for (int k = 0; k < N_CLS; k++) begin
                            acc[k] <= prod[k];
                        end
                        if (N_IN == 1) begin
                            state <= S_FINAL;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.valid_in) begin
                        for (int k = 0; k < N_CLS; k++) begin
                            acc[k] <= acc[k] + prod[k];
                        end
                        if (idx == IDX_W'(N_IN - 1)) begin
                            idx   <= '0;
                            state <= S_FINAL;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                // Class 0 goes out straight from the clamp; cnt tracks the next class.
                S_FINAL: begin
                    for (int k = 0; k < N_CLS; k++) begin
                        score[k] <= sat[k];
                    end
                    data_q  <= sat[0];
                    valid_q <= 1'b1;
                    cnt     <= CNT_W'(1);
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (cnt == CNT_W'(N_CLS)) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        state   <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end else begin
                        data_q <= score[cnt];
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.busy      = (state == S_FINAL) || (state == S_SEND) ||
                           (state == S_GAP);
endmodule

// File: tb/tb_fc_score_tx.sv
// tb_fc_score_tx: randomized self-checking bench for fc_score_tx
// against a plain-arithmetic dot-product reference model.
module tb_fc_score_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    logic        va = 1'b0;
    logic [11:0] da = '0;
    logic        vr = 1'b0;
    logic [11:0] dr = '0;

    fc_score_tx_if ia ();
    fc_score_tx_if ib ();
    fc_score_tx_if ic ();
    fc_score_tx_if ir ();

    assign ia.valid_in = va;
    assign ia.data_in  = da;
    assign ib.valid_in = va;
    assign ib.data_in  = da;
    assign ic.valid_in = va;
    assign ic.data_in  = da;
    assign ir.valid_in = vr;
    assign ir.data_in  = dr;

    function automatic int wr(int k, int i);
        return ((k * 37 + i * 11 + 5) % 256) - 128;
    endfunction

    function automatic int br(int k);
        return ((k * 29) % 200) - 100;
    endfunction

    function automatic logic [319:0] mk_wa();
        logic [319:0] r;
        r = '0;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < 4; i++)
                r[(k*4+i)*8 +: 8] = 8'(k - 4);
        return r;
    endfunction

    function automatic logic [79:0] mk_bb(input bit neg3);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(k);
        if (neg3) r[3*8 +: 8] = 8'hff;
        return r;
    endfunction

    function automatic logic [479:0] mk_wr();
        logic [479:0] r;
        r = '0;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < 6; i++)
                r[(k*6+i)*8 +: 8] = 8'(wr(k, i));
        return r;
    endfunction

    function automatic logic [79:0] mk_br();
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(br(k));
        return r;
    endfunction

    fc_score_tx #(.N_IN(4), .FRAC(0), .W_INIT(mk_wa()), .B_INIT('0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    fc_score_tx #(.N_IN(4), .FRAC(7), .W_INIT('0), .B_INIT(mk_bb(1'b0)))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    fc_score_tx #(.N_IN(4), .FRAC(7), .W_INIT('0), .B_INIT(mk_bb(1'b1)))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    fc_score_tx #(.N_IN(6), .FRAC(3), .W_INIT(mk_wr()), .B_INIT(mk_br()))
        dut_r (.clk(clk), .rst_n(rst_n), .bus(ir));

    int qa[$];
    int qa_t[$];
    int qb[$];
    int qc[$];
    int qr[$];

    always @(negedge clk) begin
        if (ia.valid_out === 1'b1) begin
            qa.push_back(int'($signed(ia.data_out)));
            qa_t.push_back(cyc);
        end
        if (ib.valid_out === 1'b1) qb.push_back(int'($signed(ib.data_out)));
        if (ic.valid_out === 1'b1) qc.push_back(int'($signed(ic.data_out)));
        if (ir.valid_out === 1'b1) qr.push_back(int'($signed(ir.data_out)));
    end

    function automatic int clamp12(longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return int'(v);
    endfunction

    // Weights k-4, no bias, no shift.
    function automatic int exp_a(int k, int xs[4]);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'(xs[i]) * (k - 4);
        return clamp12(s);
    endfunction

    // Weights wr(), biases br(), shift of 3 (floor division by 8).
    function automatic int exp_r(int k, int xs[6]);
        longint s = 0;
        for (int i = 0; i < 6; i++) s += longint'(xs[i]) * wr(k, i);
        s += longint'(br(k)) * 8;
        s = s >>> 3;
        return clamp12(s);
    endfunction

    function automatic int rnd_x();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4095)) - 2048;
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    task automatic drive_a(input int xs[4], input int gaps[4]);
        for (int i = 0; i < 4; i++) begin
            repeat (gaps[i]) begin
                @(negedge clk);
                va = 1'b0;
            end
            @(negedge clk);
            va = 1'b1;
            da = 12'(xs[i]);
        end
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic drive_r(input int xs[6], input int gaps[6]);
        for (int i = 0; i < 6; i++) begin
            repeat (gaps[i]) begin
                @(negedge clk);
                vr = 1'b0;
            end
            @(negedge clk);
            vr = 1'b1;
            dr = 12'(xs[i]);
        end
        @(negedge clk);
        vr = 1'b0;
    endtask

    task automatic wait_a(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (qa.size() >= n && ia.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_r(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (qr.size() >= n && ir.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        va = 1'b0;
        vr = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (ia.valid_out !== 1'b0) $display("FAIL rst_valid got=%b want=0", ia.valid_out);
        else n_pass++;
        n_chk++;
        if (ia.data_out !== 12'h000) $display("FAIL rst_data got=%h want=000", ia.data_out);
        else n_pass++;
        n_chk++;
        if (ia.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", ia.busy);
        else n_pass++;
        n_chk++;
        if (ir.valid_out !== 1'b0) $display("FAIL rst_valid_r got=%b want=0", ir.valid_out);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit sparse);
        int xs[4];
        int g[4];
        int t;
        bit ok;
        xs = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) g[i] = sparse ? int'($urandom_range(0, 5)) : 0;
        qa.delete();
        qa_t.delete();
        drive_a(xs, g);
        t = cyc;
        wait_a(10, ok);
        n_chk++;
        if (!ok || qa.size() != 10) $display("FAIL basic_count sp=%0d got=%0d want=10", sparse, qa.size());
        else n_pass++;
        for (int k = 0; k < 10 && k < qa.size(); k++) begin
            n_chk++;
            if (qa[k] !== 10 * k - 40)
                $display("FAIL basic_score sp=%0d k=%0d got=%0d want=%0d", sparse, k, qa[k], 10 * k - 40);
            else n_pass++;
        end
        n_chk++;
        if (qa_t.size() == 0 || qa_t[0] !== t + 1)
            $display("FAIL basic_latency sp=%0d got=%0d want=%0d", sparse, qa_t.size() ? qa_t[0] - t : -1, 1);
        else n_pass++;
        n_chk++;
        if (qa_t.size() < 10 || qa_t[9] - qa_t[0] != 9)
            $display("FAIL basic_contig sp=%0d got=%0d want=9", sparse, qa_t.size() >= 10 ? qa_t[9] - qa_t[0] : -1);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int xs[4];
        int g[4];
        bit ok;
        xs = '{2047, 2047, 2047, 2047};
        g = '{0, 0, 0, 0};
        qa.delete();
        drive_a(xs, g);
        wait_a(10, ok);
        n_chk++;
        if (!ok || qa.size() != 10) $display("FAIL sat_count got=%0d want=10", qa.size());
        else n_pass++;
        if (qa.size() == 10) begin
            n_chk++;
            if (qa[0] !== -2048) $display("FAIL sat_cls0 got=%0d want=-2048", qa[0]);
            else n_pass++;
            n_chk++;
            if (qa[4] !== 0) $display("FAIL sat_cls4 got=%0d want=0", qa[4]);
            else n_pass++;
            n_chk++;
            if (qa[9] !== 2047) $display("FAIL sat_cls9 got=%0d want=2047", qa[9]);
            else n_pass++;
            for (int k = 0; k < 10; k++) begin
                n_chk++;
                if (qa[k] !== exp_a(k, xs))
                    $display("FAIL sat_model k=%0d got=%0d want=%0d", k, qa[k], exp_a(k, xs));
                else n_pass++;
            end
        end
    endtask

    task automatic test_bias_shift();
        int xs[4];
        int g[4];
        bit ok;
        for (int i = 0; i < 4; i++) begin
            xs[i] = rnd_x();
            g[i] = 0;
        end
        qb.delete();
        qc.delete();
        qa.delete();
        drive_a(xs, g);
        wait_a(10, ok);
        n_chk++;
        if (qb.size() != 10 || qc.size() != 10)
            $display("FAIL bias_count got=%0d/%0d want=10/10", qb.size(), qc.size());
        else n_pass++;
        for (int k = 0; k < 10 && k < qb.size() && k < qc.size(); k++) begin
            n_chk++;
            if (qb[k] !== k) $display("FAIL bias_b k=%0d got=%0d want=%0d", k, qb[k], k);
            else n_pass++;
            n_chk++;
            if (qc[k] !== ((k == 3) ? -1 : k))
                $display("FAIL bias_neg k=%0d got=%0d want=%0d", k, qc[k], (k == 3) ? -1 : k);
            else n_pass++;
        end
    endtask

    task automatic test_busy_drop();
        int xs[4];
        int xs2[4];
        int g[4];
        int nb;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            xs[i] = rnd_x();
            xs2[i] = rnd_x();
            g[i] = 0;
        end
        qa.delete();
        drive_a(xs, g);
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (ia.busy === 1'b1) begin
                nb++;
                va = 1'b1;
                da = 12'd100;
            end else begin
                va = 1'b0;
            end
        end
        va = 1'b0;
        n_chk++;
        if (nb != 19) $display("FAIL busy_len got=%0d want=19", nb);
        else n_pass++;
        n_chk++;
        if (qa.size() != 10) $display("FAIL busy_img1_count got=%0d want=10", qa.size());
        else n_pass++;
        for (int k = 0; k < 10 && k < qa.size(); k++) begin
            n_chk++;
            if (qa[k] !== exp_a(k, xs))
                $display("FAIL busy_img1 k=%0d got=%0d want=%0d", k, qa[k], exp_a(k, xs));
            else n_pass++;
        end
        qa.delete();
        drive_a(xs2, g);
        wait_a(10, ok);
        n_chk++;
        if (!ok || qa.size() != 10) $display("FAIL busy_img2_count got=%0d want=10", qa.size());
        else n_pass++;
        for (int k = 0; k < 10 && k < qa.size(); k++) begin
            n_chk++;
            if (qa[k] !== exp_a(k, xs2))
                $display("FAIL busy_img2 k=%0d got=%0d want=%0d", k, qa[k], exp_a(k, xs2));
            else n_pass++;
        end
    endtask

    task automatic test_reset_send();
        int xs[4];
        int xn[4];
        int g[4];
        int seen;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            xs[i] = rnd_x();
            xn[i] = rnd_x();
            g[i] = 0;
        end
        qa.delete();
        drive_a(xs, g);
        seen = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(negedge clk);
            if (ia.valid_out === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 3) $display("FAIL rsend_seen got=%0d want=3", seen);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ia.valid_out !== 1'b0) $display("FAIL rsend_valid got=%b want=0", ia.valid_out);
        else n_pass++;
        n_chk++;
        if (ia.data_out !== 12'h000) $display("FAIL rsend_data got=%h want=000", ia.data_out);
        else n_pass++;
        rst_n = 1'b1;
        qa.delete();
        repeat (30) @(negedge clk);
        n_chk++;
        if (qa.size() != 0) $display("FAIL rsend_quiet got=%0d want=0", qa.size());
        else n_pass++;
        @(negedge clk);
        va = 1'b1;
        da = 12'(xn[0]);
        @(negedge clk);
        da = 12'(xn[1]);
        @(negedge clk);
        va = 1'b0;
        repeat (25) @(negedge clk);
        n_chk++;
        if (qa.size() != 0) $display("FAIL rsend_partial got=%0d want=0", qa.size());
        else n_pass++;
        va = 1'b1;
        da = 12'(xn[2]);
        @(negedge clk);
        da = 12'(xn[3]);
        @(negedge clk);
        va = 1'b0;
        wait_a(10, ok);
        n_chk++;
        if (!ok || qa.size() != 10) $display("FAIL rsend_fresh_count got=%0d want=10", qa.size());
        else n_pass++;
        for (int k = 0; k < 10 && k < qa.size(); k++) begin
            n_chk++;
            if (qa[k] !== exp_a(k, xn))
                $display("FAIL rsend_fresh k=%0d got=%0d want=%0d", k, qa[k], exp_a(k, xn));
            else n_pass++;
        end
    endtask

    task automatic test_random_a();
        int xs[4];
        int g[4];
        bit ok;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = rnd_x();
                g[i] = (n % 2 == 0) ? 0 : int'($urandom_range(0, 3));
            end
            qa.delete();
            drive_a(xs, g);
            wait_a(10, ok);
            n_chk++;
            if (!ok || qa.size() != 10) $display("FAIL rnd_a_count img=%0d got=%0d want=10", n, qa.size());
            else n_pass++;
            for (int k = 0; k < 10 && k < qa.size(); k++) begin
                n_chk++;
                if (qa[k] !== exp_a(k, xs))
                    $display("FAIL rnd_a img=%0d k=%0d got=%0d want=%0d", n, k, qa[k], exp_a(k, xs));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back_r();
        int xs[6];
        int g[6];
        bit ok;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 6; i++) begin
                xs[i] = rnd_x();
                g[i] = (n < 3) ? 0 : int'($urandom_range(0, 3));
            end
            qr.delete();
            drive_r(xs, g);
            wait_r(10, ok);
            n_chk++;
            if (!ok || qr.size() != 10) $display("FAIL rnd_r_count img=%0d got=%0d want=10", n, qr.size());
            else n_pass++;
            for (int k = 0; k < 10 && k < qr.size(); k++) begin
                n_chk++;
                if (qr[k] !== exp_r(k, xs))
                    $display("FAIL rnd_r img=%0d k=%0d got=%0d want=%0d", n, k, qr[k], exp_r(k, xs));
                else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic(1'b0);
        test_saturation();
        test_bias_shift();
        test_basic(1'b1);
        test_busy_drop();
        test_reset_send();
        test_random_a();
        test_back_to_back_r();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
